// File: rtl/fsm_seq_pkg.sv
// fsm_seq_pkg: shared types and constants for the fsm_seq_ctrl sequencer.
//   state_e  : 3-bit sequencer state encoding (S_IDLE .. S_CHK)
//   CHK_LEN  : number of cycles spent in S_CHK after the last phase
//   STAT_W   : width of the optional pass/fail statistics counters
//   sat_inc2 : 2-bit saturating increment used by the pulse monitors
package fsm_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_H1   = 3'd1,
    S_L1   = 3'd2,
    S_H2   = 3'd3,
    S_L2   = 3'd4,
    S_CHK  = 3'd5
  } state_e;

  localparam int unsigned CHK_LEN = 2;
  localparam int unsigned STAT_W  = 16;

  function automatic logic [1:0] sat_inc2(input logic [1:0] c, input logic inc);
    return (inc && (c != 2'b11)) ? c + 2'd1 : c;
  endfunction

endpackage

// File: rtl/fsm_seq_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   sclk    in  : clock
//   s_rst_n in  : synchronous active-low reset (pointer back to requester 0)
//   req_i   in  : request, one bit per requester
//   adv_i   in  : a grant is being taken this cycle; move the pointer
//   gnt_o   out : one-hot combinational grant (0 when nothing requests)
module rr_arb2 (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  // ptr_q names the requester that wins a tie.
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
    ptr_d = ptr_q;
    // The pointer moves away from whoever just won.
    if (adv_i && (gnt_o != 2'b00)) ptr_d = gnt_o[0];
  end

  always_ff @(posedge sclk) begin
    if (!s_rst_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl: arbitrates two requesters for one edge-pattern detector,
// drives the detector through a 1-0-1-0 pattern with the winner's hold time,
// and reports whether k2 and k1 each pulsed exactly once.
//   sclk       in  : clock
//   s_rst_n    in  : synchronous active-low reset (also resets the detector)
//   pi_req     in  : request level per requester, sampled only in S_IDLE
//   pi_hold    in  : per-requester phase length, [HOLD_W-1:0] = requester 0
//   po_gnt     out : one-hot grant held for the transaction
//   po_a       out : registered drive to the detector input
//   pi_k1      in  : detector k1 pulse
//   pi_k2      in  : detector k2 pulse
//   po_done    out : 1-cycle pass pulse
//   po_err     out : 1-cycle fail pulse
//   po_ok_cnt  out : saturating pass count   (FSM_SEQ_CNT_EN only)
//   po_err_cnt out : saturating fail count   (FSM_SEQ_CNT_EN only)
// Optional feature macro: FSM_SEQ_CNT_EN.
//
// state  | meaning
// S_IDLE | waiting for a request, outputs idle
// S_H1   | first high phase, H cycles
// S_L1   | first low phase, H cycles
// S_H2   | second high phase, H cycles
// S_L2   | second low phase, H cycles
// S_CHK  | CHK_LEN cycles for late pulses, verdict on exit
module fsm_seq_ctrl
  import fsm_seq_pkg::*;
#(
  parameter int HOLD_W = 8
) (
  input  logic                sclk,
  input  logic                s_rst_n,
  input  logic [1:0]          pi_req,
  input  logic [2*HOLD_W-1:0] pi_hold,
  output logic [1:0]          po_gnt,
  output logic                po_a,
  input  logic                pi_k1,
  input  logic                pi_k2,
  output logic                po_done,
  output logic                po_err
`ifdef FSM_SEQ_CNT_EN
  ,
  output logic [STAT_W-1:0]   po_ok_cnt,
  output logic [STAT_W-1:0]   po_err_cnt
`endif
);

  localparam logic [HOLD_W-1:0] ONE     = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] CHK_TOP = HOLD_W'(CHK_LEN - 1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              a_q, a_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        k1_q, k1_d, k2_q, k2_d;

  logic [1:0]        arb_gnt;
  logic              arb_adv;
  logic [HOLD_W-1:0] hold_sel, hold_eff;
  logic [1:0]        k1_nx, k2_nx;
  logic              tc;

  assign arb_adv = (state_q == S_IDLE) && (pi_req != 2'b00);

  rr_arb2 u_arb (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .req_i   (pi_req),
    .adv_i   (arb_adv),
    .gnt_o   (arb_gnt)
  );

  assign hold_sel = arb_gnt[1] ? pi_hold[2*HOLD_W-1:HOLD_W] : pi_hold[HOLD_W-1:0];
  assign hold_eff = (hold_sel == '0) ? ONE : hold_sel;

  // Counts include this cycle's sample so the S_CHK exit verdict sees the
  // last monitored cycle.
  assign k1_nx = sat_inc2(k1_q, pi_k1);
  assign k2_nx = sat_inc2(k2_q, pi_k2);
  assign tc    = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    k1_d    = k1_q;
    k2_d    = k2_q;

    if (state_q != S_IDLE) begin
      k1_d = k1_nx;
      k2_d = k2_nx;
    end

    case (state_q)
      S_IDLE: begin
        if (arb_gnt != 2'b00) begin
          gnt_d   = arb_gnt;
          hold_d  = hold_eff;
          cnt_d   = hold_eff - ONE;
          k1_d    = 2'b00;
          k2_d    = 2'b00;
          state_d = S_H1;
        end
      end
      S_H1, S_L1, S_H2: begin
        if (tc) begin
          cnt_d   = hold_q - ONE;
          state_d = (state_q == S_H1) ? S_L1 : (state_q == S_L1) ? S_H2 : S_L2;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_L2: begin
        if (tc) begin
          cnt_d   = CHK_TOP;
          state_d = S_CHK;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_CHK: begin
        if (tc) begin
          state_d = S_IDLE;
          gnt_d   = 2'b00;
          if ((k1_nx == 2'd1) && (k2_nx == 2'd1)) done_d = 1'b1;
          else                                    err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
    endcase

    a_d = (state_d == S_H1) || (state_d == S_H2);
  end

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= ONE;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      a_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      k1_q    <= 2'b00;
      k2_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      done_q  <= done_d;
      err_q   <= err_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
    end
  end

  assign po_gnt  = gnt_q;
  assign po_a    = a_q;
  assign po_done = done_q;
  assign po_err  = err_q;

`ifdef FSM_SEQ_CNT_EN
  logic [STAT_W-1:0] ok_cnt_q, err_cnt_q;

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (done_q && (ok_cnt_q != '1))  ok_cnt_q  <= ok_cnt_q + 1'b1;
      if (err_q  && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign po_ok_cnt  = ok_cnt_q;
  assign po_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
module tb_fsm_seq_ctrl;

  localparam int HW = 8;

  logic          sclk = 1'b0;
  logic          s_rst_n = 1'b0;
  logic [1:0]    pi_req = 2'b00;
  logic [2*HW-1:0] pi_hold = '0;
  logic [1:0]    po_gnt;
  logic          po_a;
  logic          pi_k1 = 1'b0;
  logic          pi_k2 = 1'b0;
  logic          po_done;
  logic          po_err;
`ifdef FSM_SEQ_CNT_EN
  logic [15:0]   po_ok_cnt, po_err_cnt;
  int            mdl_ok = 0, mdl_err = 0;
`endif

  fsm_seq_ctrl #(.HOLD_W(HW)) dut (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .pi_req  (pi_req),
    .pi_hold (pi_hold),
    .po_gnt  (po_gnt),
    .po_a    (po_a),
    .pi_k1   (pi_k1),
    .pi_k2   (pi_k2),
    .po_done (po_done),
    .po_err  (po_err)
`ifdef FSM_SEQ_CNT_EN
    ,
    .po_ok_cnt  (po_ok_cnt),
    .po_err_cnt (po_err_cnt)
`endif
  );

  always #5 sclk = ~sclk;

  // Edge counter: after posedge number e, cyc == e.
  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  typedef struct {
    int         g;     // grant edge
    int         d;     // edge that raises done/err
    int         h;     // effective hold
    logic [1:0] gnt;
    bit         pass;
  } txn_t;

  txn_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ptr = 0;
  int   free_edge = 0;
  int   det_mode = 0;
  int   det_h = 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Behavioural detector stub: k2 follows the second rise of po_a, k1 the
  // second fall. Modes: 0 normal, 1 no k2, 2 extra k1 in S_CHK,
  // 3 extra k1 in IDLE (harmless), 4 extra k2 in S_CHK.
  initial begin
    int k1a = -1, k1b = -1, k2a = -1, k2b = -1;
    int rises = 0, falls = 0;
    logic a_prev = 1'b0;
    forever begin
      @(negedge sclk);
      pi_k1 = (cyc == k1a) || (cyc == k1b);
      pi_k2 = (cyc == k2a) || (cyc == k2b);
      if (!s_rst_n) begin
        k1a = -1; k1b = -1; k2a = -1; k2b = -1;
        rises = 0; falls = 0; a_prev = 1'b0;
      end else begin
        if (po_gnt == 2'b00) begin
          rises = 0; falls = 0;
        end else if (po_a && !a_prev) begin
          rises++;
          if (rises == 2 && det_mode != 1) k2a = cyc + 1;
        end else if (!po_a && a_prev) begin
          falls++;
          if (falls == 2) begin
            k1a = cyc + 1;
            if (det_mode == 2) k1b = cyc + det_h + 1;
            if (det_mode == 3) k1b = cyc + det_h + 2;
            if (det_mode == 4) k2b = cyc + det_h + 1;
          end
        end
        a_prev = po_a;
      end
    end
  end

  // Monitor: expected waveform derived from the front transaction's timing.
  initial begin
    forever begin
      int e, off;
      int eg, ea, ed, ee;
      bit pop;
      @(posedge sclk);
      #2;
      e = cyc; eg = 0; ea = 0; ed = 0; ee = 0; pop = 0;
      if (q.size() > 0 && e >= q[0].g) begin
        if (e < q[0].d) begin
          eg  = int'(q[0].gnt);
          off = e - q[0].g;
          ea  = ((off < 4 * q[0].h) && (((off / q[0].h) % 2) == 0)) ? 1 : 0;
        end else if (e == q[0].d) begin
          ed  = q[0].pass ? 1 : 0;
          ee  = q[0].pass ? 0 : 1;
          pop = 1;
        end
      end
      check("po_gnt", int'(po_gnt), eg);
      check("po_a", int'(po_a), ea);
      check("po_done", int'(po_done), ed);
      check("po_err", int'(po_err), ee);
`ifdef FSM_SEQ_CNT_EN
      check("po_ok_cnt", int'(po_ok_cnt), mdl_ok);
      check("po_err_cnt", int'(po_err_cnt), mdl_err);
      if (pop) begin
        if (q[0].pass) mdl_ok++;
        else           mdl_err++;
      end
`endif
      if (pop) void'(q.pop_front());
    end
  end

  // One transaction: request at the earliest legal edge, scramble the
  // request/hold inputs while busy, optionally reset at grant+rst_at.
  task automatic do_txn(input logic [1:0] pat, input logic [7:0] h0, input logic [7:0] h1,
                        input int mode, input int gap, input int rst_at);
    txn_t t;
    int   win;
    while (cyc + 1 < free_edge) @(negedge sclk);
    pi_req  = pat;
    pi_hold = {h1, h0};
    win     = (pat == 2'b11) ? ptr : (pat[1] ? 1 : 0);
    ptr     = 1 - win;
    t.h     = (win == 1) ? int'(h1) : int'(h0);
    if (t.h == 0) t.h = 1;
    t.g     = cyc + 1;
    t.d     = t.g + 4 * t.h + 2;
    t.gnt   = (win == 1) ? 2'b10 : 2'b01;
    t.pass  = (mode == 0) || (mode == 3);
    det_mode = mode;
    det_h    = t.h;
    q.push_back(t);
    free_edge = t.d + 1;
    @(negedge sclk);
    pi_req  = 2'($urandom);
    pi_hold = 16'($urandom);
    while (cyc < t.d) begin
      if (rst_at >= 0 && cyc == t.g + rst_at) begin
        s_rst_n = 1'b0;
        q.delete();
        ptr = 0;
`ifdef FSM_SEQ_CNT_EN
        mdl_ok = 0; mdl_err = 0;
`endif
        @(negedge sclk);
        s_rst_n   = 1'b1;
        pi_req    = 2'b00;
        free_edge = cyc + 1;
        return;
      end
      @(negedge sclk);
    end
    pi_req = 2'b00;
    repeat (gap) @(negedge sclk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge sclk);
    s_rst_n = 1'b1;

    do_txn(2'b01, 8'd3, 8'd0, 0, 1, -1);            // single request, H=3
    repeat (4) do_txn(2'b11, 8'd1, 8'd1, 0, 0, -1); // contention, back-to-back
    do_txn(2'b01, 8'd2, 8'd5, 1, 1, -1);            // missing k2
    do_txn(2'b10, 8'd7, 8'd3, 2, 2, -1);            // extra k1 in S_CHK
    do_txn(2'b01, 8'd2, 8'd2, 3, 0, -1);            // k1 in IDLE ignored
    do_txn(2'b01, 8'd0, 8'd9, 0, 1, -1);            // H=0 acts as H=1
    do_txn(2'b10, 8'd4, 8'd255, 0, 1, -1);          // H=255
    do_txn(2'b10, 8'd1, 8'd1, 4, 1, -1);            // extra k2
    do_txn(2'b11, 8'd3, 8'd3, 0, 1, 7);             // reset during S_H2
    do_txn(2'b11, 8'd2, 8'd5, 0, 1, -1);            // must go to requester 0

    for (int i = 0; i < 30; i++) begin
      logic [1:0] p;
      p = 2'($urandom_range(1, 3));
      do_txn(p, 8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)),
             $urandom_range(0, 4), $urandom_range(0, 2), -1);
    end

    while (cyc + 1 < free_edge) @(negedge sclk);
    repeat (4) @(negedge sclk);
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_seq_ctrl.md
# fsm_seq_ctrl

Sequencer and arbiter for one `fsm` edge-pattern detector instance. Two requesters compete for the detector. The controller grants one requester at a time (round-robin) and drives the detector input `pi_a` through the full 1-0-1-0 pattern with the granted requester's hold time. It then checks that the detector's `po_k2` and `po_k1` pulses each occurred exactly once, and reports pass/fail to the requester.

## Interface
- `HOLD_W`, 8: width of the per-phase hold count.
- `sclk` in 1: clock.
- `s_rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `pi_req` in 2: request, one bit per requester. Level; sampled only in IDLE.
- `pi_hold` in 2*HOLD_W: per-requester phase length in cycles. Bits [HOLD_W-1:0] belong to requester 0. A value of 0 is treated as 1.
- `po_gnt` out 2: one-hot grant, held for the whole transaction.
- `po_a` out 1: registered drive to the detector `pi_a`.
- `pi_k1` in 1: detector `po_k1`.
- `pi_k2` in 1: detector `po_k2`.
- `po_done` out 1: 1-cycle pulse; transaction passed.
- `po_err` out 1: 1-cycle pulse; transaction failed.
- `po_ok_cnt` out 16: only with `FSM_SEQ_CNT_EN`.
- `po_err_cnt` out 16: only with `FSM_SEQ_CNT_EN`.

## Operation
- States:
  - `S_IDLE`: all outputs idle.
  - `S_H1`: `po_a=1`.
  - `S_L1`: `po_a=0`.
  - `S_H2`: `po_a=1`.
  - `S_L2`: `po_a=0`.
  - `S_CHK`: `po_a=0`, fixed 2 cycles.
- IDLE transition: if any `pi_req` bit is set, latch the grant and the winner's hold value H (0 becomes 1), then go to `S_H1`. Otherwise stay in IDLE.
- Phase stepping: `S_H1`, `S_L1`, `S_H2` and `S_L2` each last exactly H cycles, then step to the next state. `S_CHK` returns to `S_IDLE` after its 2 cycles.
- Arbitration: round-robin with a priority pointer.
  - The pointer starts at requester 0.
  - After each grant, the pointer moves to the other requester.
  - If only one requester is requesting, it wins regardless of the pointer.
- Pulse monitoring: sticky 2-bit saturating counters for `pi_k1` and `pi_k2`.
  - Cleared at grant.
  - Active from `S_H1` through the last `S_CHK` cycle.
  - In `S_IDLE`, `pi_k1`/`pi_k2` are ignored.
- Pass/fail check, at the `S_CHK` exit edge:
  - If k1 count == 1 and k2 count == 1, pulse `po_done`.
  - Otherwise, pulse `po_err`.
  - `po_done` and `po_err` are never asserted together.
- Request drop: a requester dropping `pi_req` mid-transaction has no effect; the transaction runs to completion.
- Reset, including mid-transaction:
  - Next edge forces `S_IDLE`, `po_a=0`, `po_gnt=0`, `po_done=0`, `po_err=0`, pointer to 0, pulse counters cleared.
  - With `FSM_SEQ_CNT_EN`, the stat counters are also cleared.
  - The detector must be reset in the same cycle; the system ties the detector's reset to `s_rst_n`.

## Timing
- Reset values: every output is 0.
- Latency:
  - Grant edge: `po_gnt` and `po_a=1` are visible in the same cycle after that edge.
  - Grant to `po_done`/`po_err`: exactly 4H+2 cycles.
- End of transaction: `po_gnt` drops on the same edge that raises `po_done`/`po_err`. The state is `S_IDLE` during the pulse cycle.
- Back-to-back: the earliest next grant is the edge that ends the done/err cycle. The IDLE gap is therefore 1 cycle minimum.
- Expected detector pulses:
  - `pi_k2` is expected 2 cycles after `S_H2` entry.
  - `pi_k1` is expected 2 cycles after `S_L2` entry.
  - Both fall inside the monitored window for all H≥1.
- Hold boundary: H = 2^HOLD_W−1 must work, with no wrap in the phase counter.

## Configuration
- `FSM_SEQ_CNT_EN` defined: `po_ok_cnt` and `po_err_cnt` are present.
  - Each increments on `po_done` / `po_err` respectively.
  - Each saturates at 16'hFFFF with no wrap.
  - Each is cleared by reset.
- `FSM_SEQ_CNT_EN` undefined: the ports and counters are absent, and all other behaviour is identical.

## Structure
- Package `fsm_seq_pkg` holds:
  - the state encodings (3-bit, `S_IDLE`…`S_CHK`);
  - the `S_CHK` length constant (2);
  - the stat-counter width (16).
- Sub-module `rr_arb2` is the 2-way round-robin arbiter:
  - inputs: request and advance;
  - outputs: one-hot grant;
  - contains the pointer register.
- Everything else lives in `fsm_seq_ctrl`.

## Test plan
- Single request: reset, `pi_req=2'b01`, H0=3, real `fsm` attached. Required: `po_a` shows 3×1, 3×0, 3×1, 3×0, and `po_done` fires 14 cycles after the grant with `po_err=0`.
- Contention: `pi_req=2'b11` continuously, H0=H1=1. Required: grants alternate 01, 10, 01, 10, each transaction gives `po_done` 6 cycles after its grant, and there is a 1-cycle IDLE gap between transactions.
- Missing pulse: use a stub detector that never asserts k2, H=2. Required: `po_err` after 10 cycles and no `po_done`.
- Extra pulse: inject a second k1 pulse during `S_CHK`. Required: `po_err`. A k1 pulse injected in IDLE has no effect.
- Hold edge cases: H=0 must behave identically to H=1 (done at 6 cycles). H=255 with HOLD_W=8 gives done at 1022 cycles.
- Mid-transaction reset: assert `s_rst_n=0` for 1 cycle during `S_H2`. Required: all outputs are 0 on the next cycle and the next grant goes to requester 0. With `FSM_SEQ_CNT_EN`, the counters read 0.
